// File: rtl/accum_defs.sv
// Shared definitions for the accumulator slice:
// FSM state encodings and datapath width.
package accum_defs;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder3.sv
// 16-bit ripple-carry adder, bit-serial carry chain.
import accum_defs::*;

module fulladder3 (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic c;

    // Carry held in a loop variable so the chain stays one comb process.
    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/accum16.sv
// Streaming 16-bit accumulator: sums a burst of len operands
// through fulladder3 and presents the result with a sticky carry.
import accum_defs::*;

module accum16 #(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic              busy
);

    state_t            state, state_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic              carry_q, carry_n;
    logic [LEN_W-1:0]  cnt, cnt_n;
    logic [LEN_W-1:0]  len_q, len_n;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;

    fulladder3 u_add (
        .x    (acc),
        .y    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            len_q   <= '0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            carry_q <= carry_n;
            cnt     <= cnt_n;
            len_q   <= len_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        carry_n = carry_q;
        cnt_n   = cnt;
        len_n   = len_q;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    acc_n   = '0;
                    carry_n = 1'b0;
                    cnt_n   = '0;
                    if (len != '0) begin
                        len_n   = len;
                        state_n = ST_ACC;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_n   = add_sum;
                    carry_n = carry_q | add_cout;
                    cnt_n   = cnt + 1'b1;
                    if (cnt == len_q - 1'b1)
                        state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Handshake flags come from state alone, never from inputs.
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_sum   = acc;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_accum16.sv
// Scoreboard bench for accum16: expected results are queued at
// burst start and popped by a monitor on each output handshake.
module tb_accum16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        busy;

    accum16 #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [16:0] expq[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: result checks and stall stability.
    logic        stalled = 1'b0;
    logic [16:0] held;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_result", {15'd0, out_carry, out_sum}, 32'hDEAD);
            end else begin
                chk("result", {15'd0, out_carry, out_sum}, {15'd0, expq.pop_front()});
                pops++;
            end
        end
        if (rst_n && out_valid && !out_ready) begin
            if (stalled)
                chk("stall_stable", {15'd0, out_carry, out_sum}, {15'd0, held});
            stalled = 1'b1;
            held    = {out_carry, out_sum};
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out", {15'd0, out_carry, out_sum}, 32'd0);
        step();

        // Basic burst: 1+2+3
        out_ready = 1'b1;
        expq.push_back({1'b0, 16'h0006});
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        chk("acc_in_ready", {31'd0, in_ready}, 32'd1);
        chk("acc_busy", {31'd0, busy}, 32'd1);
        beat(16'h0001);
        beat(16'h0002);
        chk("not_done_early", {31'd0, out_valid}, 32'd0);
        beat(16'h0003);
        chk("basic_latency", {31'd0, out_valid}, 32'd1);
        step();
        chk("basic_idle", {31'd0, busy}, 32'd0);

        // Wrap with backpressure; start during DONE ignored
        out_ready = 1'b0;
        expq.push_back({1'b1, 16'h0001});
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        beat(16'hFFFF);
        beat(16'h0002);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum", {15'd0, out_carry, out_sum}, {15'd0, 1'b1, 16'h0001});
            start = (i == 2);
            len   = 8'd0;
            step();
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        chk("wrap_idle", {31'd0, busy}, 32'd0);

        // Gapped input, start pulsed during ACC
        expq.push_back({1'b0, 16'h4000});
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat(16'h1000);
            if (b < 3) begin
                start = (b == 1);
                len   = 8'd0;
                step();
                start = 1'b0;
                step();
                chk("gap_acc", {16'd0, dut.acc}, 32'h1000 * (b + 1));
                chk("gap_cnt", {24'd0, dut.cnt}, b + 1);
                chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
            end
        end
        chk("gap_done", {31'd0, out_valid}, 32'd1);
        step();

        // Zero length
        expq.push_back(17'd0);
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("zero_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("zero_idle", {31'd0, busy}, 32'd0);

        // Reset mid-burst (no result expected)
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        beat(16'h0011);
        beat(16'h0022);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_acc", {16'd0, dut.acc}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        expq.push_back({1'b0, 16'h00AA});
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        beat(16'h00AA);
        chk("after_rst_valid", {31'd0, out_valid}, 32'd1);
        step();
        step();

        chk("queue_empty", expq.size(), 32'd0);
        chk("result_count", pops, 32'd5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum16.md
# accum16

Sequential 16-bit accumulator that sits directly downstream of the team's 16-bit ripple-carry adder `fulladder3` and is its only consumer. Operands stream in over a valid/ready handshake. Each accepted operand is added to a running sum through the adder, and a sticky carry flag records any carry-out. After a programmed number of operands, the final sum is presented on an output valid/ready port.

## Interface
Parameters:
- LEN_W, default 8: width of the operand-count field. A burst holds at most 2^LEN_W − 1 operands.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a burst. Sampled only in IDLE.
- len, input, LEN_W: number of operands in the burst. Sampled together with start.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block accepts an operand this cycle.
- in_data, input, 16: operand.
- out_valid, output, 1: out_sum and out_carry are valid.
- out_ready, input, 1: downstream accepts the result.
- out_sum, output, 16: final accumulated sum, modulo 2^16.
- out_carry, output, 1: sticky OR of every adder cout during the burst.
- busy, output, 1: state is not IDLE.

## Operation
State machine: IDLE, ACC, DONE. State is registered; in_ready, out_valid and busy are decoded from state only.

- **IDLE**
  - in_ready=0, out_valid=0.
  - On start with len≠0: latch len into len_q, set acc=0, carry_q=0, cnt=0, go to ACC.
  - On start with len=0: set acc=0, carry_q=0, go directly to DONE.
- **ACC**
  - in_ready=1.
  - On each in_valid&&in_ready: acc ← adder.sum(acc, in_data, cin=0), carry_q ← carry_q | adder.cout, cnt ← cnt+1.
  - When the accepted beat has cnt==len_q−1, go to DONE.
  - Cycles with in_valid=0 leave all state unchanged.
- **DONE**
  - out_valid=1, out_sum=acc, out_carry=carry_q.
  - On out_ready, go to IDLE.
  - out_sum and out_carry hold stable while out_valid && !out_ready.
- start is ignored in ACC and DONE. len has no effect outside the start cycle.
- Arithmetic:
  - The sum wraps modulo 2^16. Wrap is flagged only through out_carry.
  - The adder's cin is tied to 0.
  - cnt is LEN_W bits and never wraps, because len_q ≤ 2^LEN_W − 1.

## Timing
- Reset values: state=IDLE, acc=0, carry_q=0, cnt=0, len_q=0, in_ready=0, out_valid=0, out_sum=0, out_carry=0, busy=0.
- Reset asserted mid-burst clears everything immediately, asynchronously. Any partial sum is discarded.
- start in cycle T puts the block in ACC in cycle T+1, with in_ready=1.
- Throughput is one operand per cycle.
- If the last operand is accepted in cycle T, out_valid=1 in cycle T+1.
- With len=0, out_valid=1 in cycle T+1 after start, with out_sum=0 and out_carry=0.
- The out handshake in cycle T returns the block to IDLE in T+1. A new start is honoured from T+1 onward. start asserted in T itself is ignored.
- The adder path is combinational, acc → adder → acc, within a single cycle.

## Structure
- Shared package or header `accum_defs`:
  - state encodings ST_IDLE=2'd0, ST_ACC=2'd1, ST_DONE=2'd2;
  - the data width constant DATA_W=16.
- Exactly one sub-module: the existing 16-bit ripple adder `fulladder3`, instantiated once, with x=acc, y=in_data, cin=1'b0. Its sum and cout drive the next-state logic.
- FSM, counter and registers all live in accum16. No further hierarchy.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles, then release → every output is 0 and busy=0.
- **Basic burst:** start with len=3, then operands 0x0001, 0x0002, 0x0003 on consecutive cycles, out_ready=1 → out_valid exactly one cycle after the third operand, out_sum=0x0006, out_carry=0, back in IDLE the next cycle.
- **Wrap and backpressure:**
  - start with len=2, operands 0xFFFF and 0x0002 → out_sum=0x0001, out_carry=1.
  - hold out_ready=0 for 5 cycles → outputs remain stable; they release on out_ready=1.
- **Gapped input:** start with len=4, operands 0x1000 ×4, in_valid low for 2 cycles between beats → out_sum=0x4000. acc and cnt are unchanged during the gaps.
- **Zero length and ignored starts:**
  - start with len=0 → out_valid the next cycle, out_sum=0.
  - start pulsed during ACC and during DONE → no effect on the current burst.
- **Reset mid-burst:** start with len=5, accept 2 operands, pulse rst_n low asynchronously → IDLE, acc=0. A new burst with len=1 and operand 0x00AA → out_sum=0x00AA.
